// File: rtl/matmul_host_port.sv
// ----------------------------------------------------------------------------
// matmul_host_port
// Host-side companion to one matmul engine. It keeps the Q8.8 operand vector
// and the weight matrix in register files and answers engine fetches
// combinationally. It also launches a job and drains the COLS-word result
// vector, through the engine read port, onto a valid/ready stream.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_en/wr_tgt/wr_idx/wr_data
//                         host write (tgt 0 = matrix row*COLS+col, 1 = vector)
//   go                    job start pulse, honoured only in IDLE
//   busy, done            busy outside IDLE, done pulses after last word taken
//   mm_start, mm_ready    engine handshake
//   mm_sel_vec/row/col    engine fetch indices -> mm_data1 / mm_data2
//   mm_sel, mm_data_out   engine result read port
//   res_valid/ready/data/last
//                         result stream, res_last marks word COLS-1
//   job_cnt               completed-job counter (only with MATMUL_HOST_JOBCNT_EN)
//
// Build option: define MATMUL_HOST_JOBCNT_EN to add the job_cnt output.
// ----------------------------------------------------------------------------
module matmul_host_port #(
    parameter  int VEC_LEN = 2,
    parameter  int COLS    = 4,
    parameter  int RD_LAT  = 1,
    localparam int IDX_W   = $clog2(VEC_LEN * COLS),
    localparam int SV_W    = ($clog2(VEC_LEN) > 0) ? $clog2(VEC_LEN) : 1,
    localparam int SC_W    = ($clog2(COLS) > 0) ? $clog2(COLS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             wr_tgt,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [15:0]      wr_data,
    input  logic             go,
    output logic             busy,
    output logic             done,
    output logic             mm_start,
    input  logic             mm_ready,
    input  logic [SV_W-1:0]  mm_sel_vec,
    input  logic [SV_W-1:0]  mm_sel_row,
    input  logic [SC_W-1:0]  mm_sel_col,
    output logic [15:0]      mm_data1,
    output logic [15:0]      mm_data2,
    output logic [SC_W-1:0]  mm_sel,
    input  logic [15:0]      mm_data_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic             res_last
`ifdef MATMUL_HOST_JOBCNT_EN
    ,
    output logic [15:0]      job_cnt
`endif
);

    localparam int unsigned NMAT    = VEC_LEN * COLS;
    localparam logic [1:0]  LAT_END = 2'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_SETSEL,
        S_LAT,
        S_HOLD
    } state_t;

    state_t           r_state;
    logic [1:0]       r_lat;
    logic [15:0]      r_vec [VEC_LEN];
    logic [15:0]      r_mat [NMAT];
    logic [IDX_W-1:0] w_fidx;
    logic             w_cap;

    // ---------------- register files (host writes only while idle) ----------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < VEC_LEN; i++) r_vec[i] <= '0;
            for (int unsigned i = 0; i < NMAT; i++)    r_mat[i] <= '0;
        end else if (wr_en && (r_state == S_IDLE)) begin
            if (wr_tgt) begin
                if (32'(wr_idx) < VEC_LEN) r_vec[wr_idx[SV_W-1:0]] <= wr_data;
            end else begin
                if (32'(wr_idx) < NMAT) r_mat[wr_idx] <= wr_data;
            end
        end
    end

    // ---------------- combinational engine fetch ----------------------------
    always_comb begin
        mm_data1 = '0;
        mm_data2 = '0;
        w_fidx   = IDX_W'(32'(mm_sel_row) * COLS + 32'(mm_sel_col));
        if (32'(mm_sel_vec) < VEC_LEN) mm_data1 = r_vec[mm_sel_vec];
        if ((32'(mm_sel_row) < VEC_LEN) && (32'(mm_sel_col) < COLS))
            mm_data2 = r_mat[w_fidx];
    end

    // Capture point: directly in SETSEL when there is no read latency,
    // otherwise on the last LAT cycle.
    always_comb begin
        w_cap = ((r_state == S_SETSEL) && (RD_LAT == 0)) ||
                ((r_state == S_LAT) && (r_lat == LAT_END));
    end

    // ---------------- job FSM, registered outputs ---------------------------
    // mm_sel doubles as the result index k; it is 0 in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_lat     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mm_start  <= 1'b0;
            mm_sel    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_last  <= 1'b0;
`ifdef MATMUL_HOST_JOBCNT_EN
            job_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (go) begin
                        busy     <= 1'b1;
                        mm_start <= 1'b1;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    mm_start <= 1'b0;
                    r_state  <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: if (!mm_ready) r_state <= S_WAIT_DONE;
                S_WAIT_DONE: if (mm_ready)  r_state <= S_SETSEL;
                S_SETSEL: begin
                    if (!w_cap) begin
                        r_lat   <= '0;
                        r_state <= S_LAT;
                    end
                end
                S_LAT: if (!w_cap) r_lat <= r_lat + 2'd1;
                S_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_last  <= 1'b0;
                        if (mm_sel == SC_W'(COLS - 1)) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            mm_sel  <= '0;
                            r_state <= S_IDLE;
`ifdef MATMUL_HOST_JOBCNT_EN
                            job_cnt <= job_cnt + 16'd1;
`endif
                        end else begin
                            mm_sel  <= mm_sel + 1'b1;
                            r_state <= S_SETSEL;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_cap) begin
                res_data  <= mm_data_out;
                res_valid <= 1'b1;
                res_last  <= (mm_sel == SC_W'(COLS - 1));
                r_state   <= S_HOLD;
            end
        end
    end

endmodule

// File: tb/tb_matmul_host_port.sv
module tb_matmul_host_port;

    localparam int VEC_LEN = 2;
    localparam int COLS    = 4;

    logic        clk;
    logic        rst_n;
    logic        wr_en, wr_tgt, go;
    logic [2:0]  wr_idx;
    logic [15:0] wr_data;
    logic        busy, done, mm_start, mm_ready;
    logic [0:0]  mm_sel_vec, mm_sel_row;
    logic [1:0]  mm_sel_col, mm_sel;
    logic [15:0] mm_data1, mm_data2, mm_data_out;
    logic        res_valid, res_ready, res_last;
    logic [15:0] res_data;
`ifdef MATMUL_HOST_JOBCNT_EN
    logic [15:0] job_cnt;
`endif

    // fetch index sources: engine model or direct probing by the main process
    logic        probe;
    logic [0:0]  p_vec, p_row, e_vec, e_row;
    logic [1:0]  p_col, e_col;
    assign mm_sel_vec = probe ? p_vec : e_vec;
    assign mm_sel_row = probe ? p_row : e_row;
    assign mm_sel_col = probe ? p_col : e_col;

    matmul_host_port #(.VEC_LEN(VEC_LEN), .COLS(COLS), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_tgt(wr_tgt), .wr_idx(wr_idx),
        .wr_data(wr_data), .go(go), .busy(busy), .done(done), .mm_start(mm_start),
        .mm_ready(mm_ready), .mm_sel_vec(mm_sel_vec), .mm_sel_row(mm_sel_row),
        .mm_sel_col(mm_sel_col), .mm_data1(mm_data1), .mm_data2(mm_data2),
        .mm_sel(mm_sel), .mm_data_out(mm_data_out), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_last(res_last)
`ifdef MATMUL_HOST_JOBCNT_EN
        , .job_cnt(job_cnt)
`endif
    );

    // Second instance with COLS=3 so a column index of 3 is out of range.
    logic        b_wr_en, b_zero, b_one;
    logic [2:0]  b_idx;
    logic [15:0] b_wd, b_zero16, b_d1, b_d2, b_rd;
    logic [0:0]  b_sv, b_sr;
    logic [1:0]  b_sc, b_msel;
    logic        b_busy, b_done, b_start, b_rv, b_rl;
`ifdef MATMUL_HOST_JOBCNT_EN
    logic [15:0] b_jc;
`endif
    matmul_host_port #(.VEC_LEN(2), .COLS(3), .RD_LAT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_tgt(b_zero), .wr_idx(b_idx),
        .wr_data(b_wd), .go(b_zero), .busy(b_busy), .done(b_done), .mm_start(b_start),
        .mm_ready(b_one), .mm_sel_vec(b_sv), .mm_sel_row(b_sr), .mm_sel_col(b_sc),
        .mm_data1(b_d1), .mm_data2(b_d2), .mm_sel(b_msel), .mm_data_out(b_zero16),
        .res_valid(b_rv), .res_ready(b_one), .res_data(b_rd), .res_last(b_rl)
`ifdef MATMUL_HOST_JOBCNT_EN
        , .job_cnt(b_jc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_pass = 0;
    int n_total = 0;
    int jobs_started = 0;
    int jobs_done = 0;
    int jobs_aborted = 0;
    int pop_cnt = 0;
    bit bp_mode = 1'b0;

    typedef struct {
        logic [15:0] d;
        logic        l;
    } exp_t;
    exp_t sb_q[$];

    logic [15:0] m_vec [VEC_LEN];
    logic [15:0] m_mat [VEC_LEN*COLS];
    logic [15:0] eng_res [COLS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit model_busy();
        return jobs_started != (jobs_done + jobs_aborted);
    endfunction

    // Q8.8 dot product of the vector with matrix column c
    function automatic logic [15:0] ref_col(input int c);
        longint s = 0;
        for (int r = 0; r < VEC_LEN; r++)
            s += longint'($signed(m_vec[r])) * longint'($signed(m_mat[r*COLS + c]));
        return 16'(s >>> 8);
    endfunction

    // ---------------- engine model ----------------
    initial begin
        longint acc [COLS];
        e_vec = '0; e_row = '0; e_col = '0;
        mm_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (mm_start && rst_n) begin
                if ($urandom_range(0, 1) == 1) @(negedge clk);
                mm_ready = 1'b0;
                for (int c = 0; c < COLS; c++) acc[c] = 0;
                for (int c = 0; c < COLS; c++) begin
                    for (int r = 0; r < VEC_LEN; r++) begin
                        @(negedge clk);
                        e_vec = 1'(r); e_row = 1'(r); e_col = 2'(c);
                        #1;
                        acc[c] += longint'($signed(mm_data1)) * longint'($signed(mm_data2));
                    end
                end
                for (int c = 0; c < COLS; c++) eng_res[c] = 16'(acc[c] >>> 8);
                @(negedge clk);
                mm_ready = 1'b1;
            end
        end
    end

    // engine result port: data follows mm_sel one cycle late
    initial begin
        logic [1:0] sel_d;
        sel_d = '0;
        mm_data_out = '0;
        for (int c = 0; c < COLS; c++) eng_res[c] = '0;
        forever begin
            @(negedge clk);
            mm_data_out = eng_res[sel_d];
            sel_d = mm_sel;
        end
    end

    // ---------------- result consumer ----------------
    initial begin
        int stall;
        stall = 0;
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (bp_mode) begin
                if (!res_valid) res_ready = 1'b0;
                else if (stall < 5) begin res_ready = 1'b0; stall++; end
                else begin res_ready = 1'b1; stall = 0; end
            end else begin
                res_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit          exp_done, stalled;
        logic [15:0] st_d;
        logic        st_l;
        exp_t        e;
        exp_done = 1'b0; stalled = 1'b0; st_d = '0; st_l = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_done = 1'b0;
                stalled  = 1'b0;
            end else begin
                check("done_pulse", 32'(done), 32'(exp_done));
                if (exp_done) jobs_done++;
                exp_done = 1'b0;
                if (stalled) begin
                    check("stall_valid", 32'(res_valid), 32'd1);
                    check("stall_data", 32'(res_data), 32'(st_d));
                    check("stall_last", 32'(res_last), 32'(st_l));
                end
                stalled = 1'b0;
                if (res_valid && res_ready) begin
                    if (sb_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_word: got %h with no word outstanding", res_data);
                    end else begin
                        e = sb_q.pop_front();
                        check("res_data", 32'(res_data), 32'(e.d));
                        check("res_last", 32'(res_last), 32'(e.l));
                        pop_cnt++;
                        if (e.l) exp_done = 1'b1;
                    end
                end else if (res_valid) begin
                    stalled = 1'b1;
                    st_d = res_data;
                    st_l = res_last;
                end
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic wr(input bit tgt, input int idx, input logic [15:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_tgt = tgt; wr_idx = 3'(idx); wr_data = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
        if (!model_busy()) begin
            if (tgt && idx < VEC_LEN) m_vec[idx] = d;
            if (!tgt && idx < VEC_LEN*COLS) m_mat[idx] = d;
        end
    endtask

    task automatic go_job(input bit with_wr, input bit tgt, input int idx, input logic [15:0] d);
        bit was_busy;
        was_busy = model_busy();
        @(negedge clk);
        go = 1'b1;
        if (with_wr) begin wr_en = 1'b1; wr_tgt = tgt; wr_idx = 3'(idx); wr_data = d; end
        @(posedge clk);
        #1 go = 1'b0; wr_en = 1'b0;
        check("busy_after_go", 32'(busy), 32'd1);
        if (!was_busy) begin
            if (with_wr && tgt && idx < VEC_LEN) m_vec[idx] = d;
            if (with_wr && !tgt && idx < VEC_LEN*COLS) m_mat[idx] = d;
            for (int c = 0; c < COLS; c++) sb_q.push_back('{ref_col(c), (c == COLS-1)});
            jobs_started++;
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000 && model_busy(); i++) @(posedge clk);
        if (model_busy()) begin
            n_total++;
            $display("FAIL %s: job did not complete within 3000 cycles", name);
        end
        repeat (2) @(posedge clk);
        check({name, "_busy_idle"}, 32'(busy), 32'd0);
        check({name, "_queue_empty"}, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic load_basic();
        logic [15:0] r0 [COLS];
        r0[0] = 16'h0100; r0[1] = 16'h0200; r0[2] = 16'h0300; r0[3] = 16'h0400;
        wr(1'b1, 0, 16'h0100);
        wr(1'b1, 1, 16'h0200);
        for (int c = 0; c < COLS; c++) wr(1'b0, c, r0[c]);
        for (int c = 0; c < COLS; c++) wr(1'b0, COLS + c, 16'h0080);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_mm_start"}, 32'(mm_start), 32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_res_last"}, 32'(res_last), 32'd0);
        check({tag, "_mm_sel"}, 32'(mm_sel), 32'd0);
        check({tag, "_res_data"}, 32'(res_data), 32'd0);
        probe = 1'b1;
        for (int r = 0; r < VEC_LEN; r++) begin
            for (int c = 0; c < COLS; c++) begin
                p_vec = 1'(r); p_row = 1'(r); p_col = 2'(c);
                #1;
                check({tag, "_data1_zero"}, 32'(mm_data1), 32'd0);
                check({tag, "_data2_zero"}, 32'(mm_data2), 32'd0);
            end
        end
        probe = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int pop_base;
        int jc_base;
        rst_n = 1'b1; wr_en = 1'b0; wr_tgt = 1'b0; wr_idx = '0; wr_data = '0; go = 1'b0;
        probe = 1'b0; p_vec = '0; p_row = '0; p_col = '0;
        b_wr_en = 1'b0; b_zero = 1'b0; b_one = 1'b1; b_idx = '0; b_wd = '0; b_zero16 = '0;
        b_sv = '0; b_sr = '0; b_sc = '0;
        for (int i = 0; i < VEC_LEN; i++) m_vec[i] = '0;
        for (int i = 0; i < VEC_LEN*COLS; i++) m_mat[i] = '0;
        jc_base = 0;

        // asynchronous reset asserted mid-cycle
        #2 rst_n = 1'b0;
        #1 check_reset_state("reset");
        @(negedge clk) rst_n = 1'b1;

        // out-of-range column fetch on the COLS=3 instance
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            b_wr_en = 1'b1; b_idx = 3'(i); b_wd = 16'h1000 + 16'(i);
        end
        @(negedge clk) b_wr_en = 1'b0;
        b_sr = 1'b0; b_sc = 2'd3; #1 check("oob_col_row0", 32'(b_d2), 32'd0);
        b_sr = 1'b1; b_sc = 2'd3; #1 check("oob_col_row1", 32'(b_d2), 32'd0);
        b_sr = 1'b1; b_sc = 2'd2; #1 check("inrange_r1c2", 32'(b_d2), 32'h1005);
        b_sr = 1'b0; b_sc = 2'd1; #1 check("inrange_r0c1", 32'(b_d2), 32'h1001);

        // basic job
        load_basic();
        go_job(1'b0, 1'b0, 0, '0);
        wait_idle("basic");

        // backpressure
        bp_mode = 1'b1;
        go_job(1'b0, 1'b0, 0, '0);
        wait_idle("backpressure");
        bp_mode = 1'b0;

        // blocked write and go while busy, then identical rerun
        go_job(1'b0, 1'b0, 0, '0);
        repeat (3) @(posedge clk);
        wr(1'b1, 0, 16'h7F00);
        go_job(1'b0, 1'b0, 0, '0);
        wait_idle("blocked");
        go_job(1'b0, 1'b0, 0, '0);
        wait_idle("rerun");

        // out-of-range vector writes are dropped
        wr(1'b1, 2, 16'h7777);
        wr(1'b1, 7, 16'h5555);
        go_job(1'b0, 1'b0, 0, '0);
        wait_idle("vec_bounds");

        // write and go in the same cycle
        go_job(1'b1, 1'b1, 1, 16'h0300);
        wait_idle("write_with_go");

        // randomized jobs
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < VEC_LEN; i++) wr(1'b1, i, 16'($urandom));
            for (int i = 0; i < VEC_LEN*COLS; i++) wr(1'b0, i, 16'($urandom));
            bp_mode = (j == 2);
            go_job(1'b0, 1'b0, 0, '0);
            wait_idle("random");
        end
        bp_mode = 1'b0;

`ifdef MATMUL_HOST_JOBCNT_EN
        check("job_cnt", 32'(job_cnt), 32'(jobs_done - jc_base));
`endif

        // reset after the second word is accepted
        pop_base = pop_cnt;
        go_job(1'b0, 1'b0, 0, '0);
        for (int i = 0; i < 3000 && pop_cnt < pop_base + 2; i++) @(posedge clk);
        if (pop_cnt < pop_base + 2) begin
            n_total++;
            $display("FAIL mid_drain_wait: got %0d words expected 2", pop_cnt - pop_base);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        sb_q.delete();
        jobs_aborted++;
        jc_base = jobs_done;
        for (int i = 0; i < VEC_LEN; i++) m_vec[i] = '0;
        for (int i = 0; i < VEC_LEN*COLS; i++) m_mat[i] = '0;
        #1 check_reset_state("mid_reset");
        @(negedge clk) rst_n = 1'b1;

        load_basic();
        go_job(1'b0, 1'b0, 0, '0);
        wait_idle("after_reset");

`ifdef MATMUL_HOST_JOBCNT_EN
        check("job_cnt_after_reset", 32'(job_cnt), 32'(jobs_done - jc_base));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
